fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, width of PC and instruction.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset; sampled only on rising clk.
REQ-005 SHALL have port imem_addr, output, 12, word address to synchronous imem; equals pc[11:0].
REQ-006 SHALL have port imem_q, input, DWIDTH, imem read data, valid the cycle after the address was presented.
REQ-007 SHALL have port redirect_valid, input, 1, branch/jump redirect request.
REQ-008 SHALL have port redirect_pc, input, DWIDTH, redirect target word address.
REQ-009 SHALL have port out_valid, output, 1, instruction available to decode.
REQ-010 SHALL have port out_ready, input, 1, decode accepts head entry.
REQ-011 SHALL have port out_insn, output, DWIDTH, head instruction.
REQ-012 SHALL have port out_pc, output, DWIDTH, word PC of head instruction.

Function
REQ-013 SHALL hold internal fetch PC register pc (word address), a 2-entry FIFO of {insn, pc}, an inflight flag and inflight_pc register.
REQ-014 SHALL define pop = out_valid && out_ready; a pop removes the FIFO head at the clock edge.
REQ-015 SHALL issue a fetch in cycle t when no redirect is sampled and (occ + inflight < 2, or occ + inflight == 2 with pop in t).
REQ-016 On issue: inflight<=1, inflight_pc<=pc, pc<=pc+1 (mod 2^DWIDTH); no issue: pc holds, inflight<=0.
REQ-017 When inflight==1 in cycle t+1, imem_q with inflight_pc SHALL be written to the FIFO tail at end of t+1; out_valid SHALL rise in t+2 (issue-to-output latency 2).
REQ-018 Sustained throughput with out_ready held 1 SHALL be one instruction per cycle.
REQ-019 FIFO SHALL never overflow; simultaneous write and pop at occ==2 is legal, occ unchanged.
REQ-020 out_valid = (occ != 0); out_insn/out_pc SHALL be 0 when occ==0.
REQ-021 Output SHALL hold out_insn/out_pc stable while out_valid && !out_ready.
REQ-022 On redirect_valid in cycle t: a pop in t completes normally; then FIFO flushed, inflight data returning in t+1 discarded, pc<=redirect_pc, no issue in t.
REQ-023 After redirect in t: fetch of redirect_pc issued in t+1, out_valid with out_pc=redirect_pc in t+3.
REQ-024 Back-to-back redirects: latest wins; each restarts the REQ-023 timeline.
REQ-025 imem_addr SHALL wrap 0xFFF->0x000 with pc; pc wraps 0xFFFFFFFF->0x00000000.

Reset
REQ-026 While rst==0 at a rising edge: pc<=RESET_PC, FIFO empty, inflight<=0; next cycle out_valid=0, out_insn=0, out_pc=0, imem_addr=RESET_PC[11:0].
REQ-027 Reset SHALL override redirect and pop in the same cycle; data returning after reset is discarded.
REQ-028 rst toggling between clock edges SHALL have no effect.
REQ-029 First fetch after release issued in first cycle with rst==1; first out_valid two cycles later.

Verification
REQ-030 Reset release, out_ready=1, imem_q=addr: out_pc 0,1,2,3 on consecutive cycles from cycle 2, out_insn matches.
REQ-031 out_ready=0 for 5 cycles after first valid: out_pc holds 0, pc stops at 2 (two fetches); release -> out_pc 0,1,2 consecutive, no gap or duplicate.
REQ-032 Redirect to 0x100 with occ==1 and fetch inflight: both old entries dropped, out_valid=0 for t+1..t+2, out_pc=0x100 in t+3.
REQ-033 Redirect same cycle as pop of pc 5: pc 5 counted as consumed once, no entry with pc 6 ever appears.
REQ-034 Redirect to 0xFFFFFFFF: out_pc 0xFFFFFFFF then 0x00000000; imem_addr 0xFFF then 0x000.
REQ-035 rst=0 for one edge mid-stream with out_valid=1: next cycle out_valid=0, imem_addr=0; stream resumes at pc 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem, redirect and decode-side signals of the fetch unit
interface fetch_unit_if #(parameter int DWIDTH = 32);
  logic [11:0]       imem_addr;
  logic [DWIDTH-1:0] imem_q;
  logic              redirect_valid;
  logic [DWIDTH-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_insn;
  logic [DWIDTH-1:0] out_pc;
  modport master (
    output imem_addr, out_valid, out_insn, out_pc,
    input  imem_q, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_addr, out_valid, out_insn, out_pc,
    output imem_q, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer feeding a 2-entry instruction FIFO from a synchronous imem
module fetch_unit #(
  parameter int                DWIDTH   = 32,
  parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
  input logic         clk,
  input logic         rst,
  fetch_unit_if.master bus
);
  logic [DWIDTH-1:0] pc_q, inflight_pc_q;
  logic              inflight_q;
  logic [1:0]        occ_q;
  logic [DWIDTH-1:0] insn_q [2];
  logic [DWIDTH-1:0] epc_q  [2];
  logic              pop, issue, wpos;
  logic [1:0]        pend;
  // Slots already claimed (stored + in flight) decide whether a new fetch fits
  always_comb begin
    pop   = (occ_q != 2'd0) && bus.out_ready;
    pend  = occ_q + {1'b0, inflight_q};
    issue = !bus.redirect_valid && (pend < 2'd2 || (pend == 2'd2 && pop));
    wpos  = occ_q[0] ^ pop;
  end
  assign bus.imem_addr = pc_q[11:0];
  assign bus.out_valid = occ_q != 2'd0;
  assign bus.out_insn  = bus.out_valid ? insn_q[0] : '0;
  assign bus.out_pc    = bus.out_valid ? epc_q[0] : '0;
  // PC advance, FIFO shift-on-pop with tail write of returning data, flush on redirect
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else if (bus.redirect_valid) begin
      pc_q       <= bus.redirect_pc;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
    end else begin
      if (pop) begin
        insn_q[0] <= insn_q[1];
        epc_q[0]  <= epc_q[1];
      end
      if (inflight_q) begin
        insn_q[wpos] <= bus.imem_q;
        epc_q[wpos]  <= inflight_pc_q;
      end
      occ_q      <= occ_q - {1'b0, pop} + {1'b0, inflight_q};
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + DWIDTH'(1);
      end
    end
  end
endmodule
